// File: rtl/bird_column_if.sv
// Bird-column control/status bundle.
//   master : game side, drives active/freeze/press/pipe_mask and observes the bird.
//   slave  : bird_column itself.
// Ports carried:
//   active, freeze, press : play enable, game-over hold, flap button (synchronised level)
//   pipe_mask [ROWS]      : rows occupied by a pipe in this column
//   light [ROWS]          : one-hot bird position for the LED matrix
//   row                   : bird row index (0 = bottom)
//   dead, tick            : game-over flag, one-cycle game tick pulse
interface bird_column_if #(
  parameter int ROWS = 8
);
  localparam int RW = $clog2(ROWS);

  logic            active;
  logic            freeze;
  logic            press;
  logic [ROWS-1:0] pipe_mask;
  logic [ROWS-1:0] light;
  logic [RW-1:0]   row;
  logic            dead;
  logic            tick;

  modport master (
    output active, freeze, press, pipe_mask,
    input  light, row, dead, tick
  );

  modport slave (
    input  active, freeze, press, pipe_mask,
    output light, row, dead, tick
  );
endinterface

// File: rtl/bird_column.sv
// bird_column: owns the bird's row in one LED column of the Flappy Bird game.
// Gravity accelerates the bird by one row/tick per game tick up to MAX_FALL, a
// rising edge of the button schedules a flap of FLAP_RISE rows for the next
// tick, and ceiling / floor / pipe collisions are resolved every cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : bird_column_if.slave (active, freeze, press, pipe_mask in;
//                light, row, dead, tick out)
module bird_column #(
  parameter int ROWS      = 8,
  parameter int TICK_DIV  = 64,
  parameter int START_ROW = 4,
  parameter int FLAP_RISE = 2,
  parameter int MAX_FALL  = 2
) (
  input  logic          clk,
  input  logic          reset,
  bird_column_if.slave  bus
);
  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(MAX_FALL + 1);
  localparam int CW = $clog2(TICK_DIV);
  // Wide enough that row+FLAP_RISE and row-vs-speed comparisons never wrap.
  localparam int AW = $clog2(ROWS + FLAP_RISE + MAX_FALL) + 1;

  localparam logic [RW-1:0] START_R  = RW'(START_ROW);
  localparam logic [RW-1:0] TOP_R    = RW'(ROWS - 1);
  localparam logic [RW-1:0] RISE_R   = RW'(FLAP_RISE);
  localparam logic [AW-1:0] TOP_A    = AW'(ROWS - 1);
  localparam logic [AW-1:0] RISE_A   = AW'(FLAP_RISE);
  localparam logic [FW-1:0] MAXF     = FW'(MAX_FALL);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

  state_t        state_reg;
  logic [RW-1:0] row_reg;
  logic [FW-1:0] fs_reg;
  logic [CW-1:0] cnt_reg;
  logic          pend_reg;
  logic          press_q_reg;

  logic          running;
  logic          tick_w;
  logic          press_rise;
  logic          flap_now;
  logic          collide;
  logic [AW-1:0] row_wide;
  logic [AW-1:0] rise_sum;
  logic [AW-1:0] fs_wide;
  logic [FW-1:0] fs_inc;
  logic          underflow;
  logic [RW-1:0] row_flap;
  logic [RW-1:0] row_fall;

  // Play logic only advances in PLAY while enabled and not held.
  assign running    = (state_reg == PLAY) && bus.active && !bus.freeze;
  assign tick_w     = running && (cnt_reg == CNT_LAST);
  assign press_rise = bus.press && !press_q_reg;
  assign flap_now   = pend_reg || press_rise;
  assign collide    = running && bus.pipe_mask[row_reg];

  always_comb begin
    row_wide  = AW'(row_reg);
    rise_sum  = row_wide + RISE_A;
    fs_inc    = (fs_reg >= MAXF) ? MAXF : fs_reg + FW'(1);
    fs_wide   = AW'(fs_inc);
    underflow = row_wide < fs_wide;
    // Both results are only used when they fit in RW bits.
    row_flap  = (rise_sum > TOP_A) ? TOP_R : row_reg + RISE_R;
    row_fall  = row_reg - RW'(fs_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      press_q_reg <= 1'b0;
      state_reg   <= IDLE;
      row_reg     <= START_R;
      fs_reg      <= '0;
      cnt_reg     <= '0;
      pend_reg    <= 1'b0;
    end else begin
      press_q_reg <= bus.press;
      if (!bus.active) begin
        state_reg <= IDLE;
        row_reg   <= START_R;
        fs_reg    <= '0;
        cnt_reg   <= '0;
        pend_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= PLAY;
          PLAY: begin
            if (!bus.freeze) begin
              if (collide) begin
                // Collision beats a coincident tick: row/speed/counter hold.
                state_reg <= DEAD;
              end else begin
                cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
                if (tick_w) begin
                  pend_reg <= 1'b0;
                  if (flap_now) begin
                    row_reg <= row_flap;
                    fs_reg  <= '0;
                  end else begin
                    fs_reg <= fs_inc;
                    if (underflow) begin
                      row_reg   <= '0;
                      state_reg <= DEAD;
                    end else begin
                      row_reg <= row_fall;
                    end
                  end
                end else if (press_rise) begin
                  pend_reg <= 1'b1;
                end
              end
            end
          end
          DEAD: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_light
      assign bus.light[gi] = (row_reg == RW'(gi));
    end
  endgenerate

  assign bus.row  = row_reg;
  assign bus.dead = (state_reg == DEAD);
  assign bus.tick = tick_w;
endmodule

// File: tb/tb_bird_column.sv
// Bench for bird_column: directed scenarios followed by random play. A driver
// applies inputs each cycle and pushes the reference model's expected outputs
// into a queue; an independent monitor pops and compares them.
module tb_bird_column;
  localparam int ROWS = 8, TICK_DIV = 4, START_ROW = 4, FLAP_RISE = 2, MAX_FALL = 2;
  localparam int M_IDLE = 0, M_PLAY = 1, M_DEAD = 2;

  typedef struct {
    logic [7:0] light;
    logic [2:0] row;
    logic       dead;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bird_column_if #(.ROWS(ROWS)) bif ();

  bird_column #(
    .ROWS(ROWS), .TICK_DIV(TICK_DIV), .START_ROW(START_ROW),
    .FLAP_RISE(FLAP_RISE), .MAX_FALL(MAX_FALL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;

  // Reference model: game-level quantities kept as plain integers.
  int mode    = M_IDLE;
  int bird    = START_ROW;
  int speed   = 0;
  int played  = 0;   // unfrozen, alive PLAY cycles since entering PLAY
  bit pending = 1'b0;
  bit last_press = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, n_cycle, act, req);
    end
  endtask

  // Drive one cycle of inputs and predict what the DUT shows during that cycle.
  task automatic step(input bit a, input bit f, input bit p, input logic [7:0] m);
    exp_t e;
    bit   is_tick, rising;
    int   nxt;
    @(negedge clk);
    reset = 1'b0;
    bif.active    = a;
    bif.freeze    = f;
    bif.press     = p;
    bif.pipe_mask = m;

    is_tick = (mode == M_PLAY) && a && !f && (played % TICK_DIV == TICK_DIV - 1);
    e.row   = 3'(bird);
    e.light = 8'(1 << bird);
    e.dead  = (mode == M_DEAD);
    e.tick  = is_tick;
    exp_q.push_back(e);

    rising     = p && !last_press;
    last_press = p;
    if (!a) begin
      mode = M_IDLE; bird = START_ROW; speed = 0; played = 0; pending = 1'b0;
    end else if (mode == M_IDLE) begin
      mode = M_PLAY;
    end else if (mode == M_PLAY && !f) begin
      if (m[bird]) begin
        mode = M_DEAD;
      end else begin
        played++;
        if (is_tick) begin
          if (pending || rising) begin
            bird  = (bird + FLAP_RISE > ROWS - 1) ? ROWS - 1 : bird + FLAP_RISE;
            speed = 0;
          end else begin
            speed = (speed + 1 > MAX_FALL) ? MAX_FALL : speed + 1;
            nxt   = bird - speed;
            if (nxt < 0) begin
              bird = 0;
              mode = M_DEAD;
            end else begin
              bird = nxt;
            end
          end
          pending = 1'b0;
        end else if (rising) begin
          pending = 1'b1;
        end
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("row",   32'(bif.row),   32'(e.row));
        chk("light", 32'(bif.light), 32'(e.light));
        chk("dead",  32'(bif.dead),  32'(e.dead));
        chk("tick",  32'(bif.tick),  32'(e.tick));
      end
      n_cycle++;
    end
  end

  initial begin
    bit   rp;
    bit   rf;
    logic [7:0] rm;
    bif.active = 1'b0; bif.freeze = 1'b0; bif.press = 1'b0; bif.pipe_mask = '0;
    repeat (3) @(posedge clk);

    // Idle after reset: random press/mask must have no effect.
    repeat (20) step(0, 0, 1'($urandom_range(1)), 8'($urandom));
    // Free fall 4 -> 3 -> 1 -> floor death, then hold in DEAD.
    repeat (18) step(1, 0, 0, '0);
    // One cycle of active low leaves DEAD.
    step(0, 0, 0, '0);
    // Flap at row 3 with speed 1, press held for two tick periods.
    repeat (5) step(1, 0, 0, '0);
    repeat (8) step(1, 0, 1, '0);
    repeat (2) step(1, 0, 0, '0);
    // Two edges inside one period give a single flap.
    step(1, 0, 1, '0); step(1, 0, 0, '0); step(1, 0, 1, '0); step(1, 0, 0, '0);
    repeat (4) step(1, 0, 0, '0);
    // Flap every period: climb to the ceiling and stay there alive.
    repeat (6) begin
      step(1, 0, 1, '0);
      repeat (3) step(1, 0, 0, '0);
    end
    // Pipe at row 4 mid-period.
    step(0, 0, 0, '0); step(1, 0, 0, '0);
    repeat (4) step(1, 0, 0, 8'h10);
    // Pipe appearing exactly on the tick cycle.
    step(0, 0, 0, '0); step(1, 0, 0, '0);
    repeat (3) step(1, 0, 0, '0);
    step(1, 0, 0, 8'h10);
    repeat (3) step(1, 0, 0, '0);
    // Freeze for 10 cycles with pipes everywhere and press edges.
    step(0, 0, 0, '0); step(1, 0, 0, '0);
    repeat (2) step(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) step(1, 1, 1'(i % 2), 8'hFF);
    repeat (12) step(1, 0, 0, '0);

    // Random play.
    rp = 1'b0; rf = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(4) == 0) rp = ~rp;
      if ($urandom_range(7) == 0) rf = ~rf;
      rm = ($urandom_range(15) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
      step(($urandom_range(63) != 0), rf && ($urandom_range(1) == 0), rp, rm);
    end

    // Let the monitor drain the scoreboard within a bounded time.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
